// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencer.
package ex_muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3 encodings of the M-extension R-type ops
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM
    function automatic logic md_signed_a(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM
    function automatic logic md_signed_b(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_md_iter_core.sv
// Iterative datapath: one shift-add multiply or restoring divide step per cycle
// on unsigned magnitudes. hi/lo share storage: {acc_hi, multiplier/prod_lo}
// for multiply, {remainder, dividend/quotient} for divide.
module md_iter_core #(
    parameter int XLEN = 32,
    localparam int CW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_hi_nxt,
    output logic [XLEN-1:0] o_lo_nxt
);

    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic [XLEN:0]   w_sum, w_trial, w_diff;

    assign o_last = (r_cnt == '0);

    // next-step value; exposed so the final step can be sign-fixed in the same cycle
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, r_b};
        w_trial = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_trial - {1'b0, r_b};
        o_hi_nxt = r_hi;
        o_lo_nxt = r_lo;
        if (r_is_div) begin
            // no borrow out of the trial subtract means the quotient bit is 1
            if (!w_diff[XLEN]) begin
                o_hi_nxt = w_diff[XLEN-1:0];
                o_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi_nxt = w_trial[XLEN-1:0];
                o_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else if (r_lo[0]) begin
            {o_hi_nxt, o_lo_nxt} = {w_sum, r_lo[XLEN-1:1]};
        end else begin
            {o_hi_nxt, o_lo_nxt} = {1'b0, r_hi, r_lo[XLEN-1:1]};
        end
    end

    // operand load on accept, one iteration per step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
            r_cnt    <= CW'(XLEN - 1);
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_hi     <= o_hi_nxt;
            r_lo     <= o_lo_nxt;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: accepts one MUL/DIV op, stalls the pipe while the
// iterative core runs, then pulses result_valid_o with the sign-fixed result.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);

    md_state_e       r_state;
    md_op_e          r_op;
    logic            r_neg_q, r_neg_r;
    logic [XLEN-1:0] r_result;

    md_op_e          w_op;
    logic            w_sa, w_sb, w_accept, w_div_zero, w_ovf, w_last;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special, w_hi_nxt, w_lo_nxt, w_final;
    logic [2*XLEN-1:0] w_prod;

    // operand magnitudes and special-case detection at accept
    always_comb begin
        w_op       = md_op_e'(md_op_i);
        w_sa       = md_signed_a(w_op) & rs1_i[XLEN-1];
        w_sb       = md_signed_b(w_op) & rs2_i[XLEN-1];
        w_abs_a    = w_sa ? -rs1_i : rs1_i;
        w_abs_b    = w_sb ? -rs2_i : rs2_i;
        w_accept   = (r_state == MD_IDLE) & valid_i & ~flush_i;
        w_div_zero = md_is_div(w_op) && (rs2_i == '0);
        w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        w_special  = '0;
        if (w_div_zero)
            w_special = md_is_rem(w_op) ? rs1_i : '1;
        else if (w_ovf)
            w_special = md_is_rem(w_op) ? '0 : rs1_i;
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_load   (w_accept),
        .i_step   ((r_state == MD_CALC) & ~flush_i),
        .i_is_div (md_is_div(w_op)),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_last   (w_last),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // sign fix and slice select applied to the final iteration's output
    always_comb begin
        w_prod = {w_hi_nxt, w_lo_nxt};
        if (r_neg_q)
            w_prod = -w_prod;
        case (r_op)
            MD_MUL:                       w_final = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_final = r_neg_q ? -w_lo_nxt : w_lo_nxt;
            MD_REM, MD_REMU:              w_final = r_neg_r ? -w_hi_nxt : w_hi_nxt;
            default:                      w_final = '0;
        endcase
    end

    // sequencer FSM; flush aborts from any busy state without producing a result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_op     <= MD_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (flush_i) begin
                        r_state <= MD_IDLE;
                    end else if (w_last) begin
                        r_result <= w_final;
                        r_state  <= MD_DONE;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign stall_o        = ~flush_i & (((r_state == MD_IDLE) & valid_i) | (r_state == MD_CALC));
    assign result_valid_o = ~flush_i & (r_state == MD_DONE);
    assign result_o       = r_result;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: latency, stall window, signed/unsigned
// results, special cases, flush and mid-operation reset.
module tb_ex_muldiv_sequencer;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n, valid_i, flush_i, stall_o, result_valid_o;
    logic [2:0]  md_op_i;
    logic [31:0] rs1_i, rs2_i, result_o;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .md_op_i        (md_op_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    // present one op for a single cycle; reports stall_o seen in the accept cycle
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic acc_stall);
        @(negedge clk);
        valid_i = 1'b1; md_op_i = op; rs1_i = a; rs2_i = b;
        #1 acc_stall = stall_o;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    // cycles after accept until result_valid_o; lat=-1 on timeout
    task automatic wait_result(output logic [31:0] res, output int lat, output int stall_bad);
        res = 'x; stall_bad = 0; lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (result_valid_o) begin
                res = result_o; lat = k;
                if (stall_o) stall_bad++;
                break;
            end else if (!stall_o) stall_bad++;
        end
    endtask

    // count result pulses and stall assertions over an idle window
    task automatic watch_idle(input int n, output int rv_cnt, output int st_cnt);
        rv_cnt = 0; st_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (result_valid_o) rv_cnt++;
            if (stall_o) st_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; md_op_i = '0; rs1_i = '0; rs2_i = '0;
        #12;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid_o); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic acc; logic [31:0] res; int lat, sb;
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, acc);
        wait_result(res, lat, sb);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL mul_accept_stall: got %b want 1", acc); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
        checks++; if (sb != 0) begin errors++; $display("FAIL mul_stall_window: %0d bad cycles want 0", sb); end
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    endtask

    task automatic test_mulh_family();
        logic [2:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] a   [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b   [3] = '{32'h8000_0000, 32'h8000_0000, 32'd2};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        logic acc; logic [31:0] res; int lat, sb;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], a[i], b[i], acc);
            wait_result(res, lat, sb);
            checks++; if (res !== exp[i] || lat != 33) begin
                errors++; $display("FAIL mulh_%0d: got %h lat %0d want %h lat 33", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic acc; logic [31:0] res; int lat, sb;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], a[i], b[i], acc);
            wait_result(res, lat, sb);
            checks++; if (res !== exp[i] || lat != 33 || sb != 0) begin
                errors++; $display("FAIL div_%0d: got %h lat %0d stall_bad %0d want %h lat 33", i, res, lat, sb, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [6] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REMU};
        logic [31:0] a   [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'hDEAD_BEEF};
        logic [31:0] b   [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        logic acc; logic [31:0] res; int lat, sb;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], a[i], b[i], acc);
            wait_result(res, lat, sb);
            checks++; if (res !== exp[i] || lat != 1 || acc !== 1'b1) begin
                errors++; $display("FAIL special_%0d: got %h lat %0d stall %b want %h lat 1 stall 1", i, res, lat, acc, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc; logic [31:0] res; int lat, sb;
        issue(OP_MUL, 32'd3, 32'd5, acc);
        wait_result(res, lat, sb);
        checks++; if (res !== 32'd15 || lat != 33) begin errors++; $display("FAIL b2b_mul: got %h lat %0d want f lat 33", res, lat); end
        issue(OP_REMU, 32'd9, 32'd4, acc);
        wait_result(res, lat, sb);
        checks++; if (res !== 32'd1 || lat != 33) begin errors++; $display("FAIL b2b_remu: got %h lat %0d want 1 lat 33", res, lat); end
    endtask

    task automatic test_flush();
        logic acc; int rv, st;
        // abort mid-CALC
        issue(OP_MUL, 32'd7, 32'd9, acc);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_calc_now: stall %b valid %b want 0 0", stall_o, result_valid_o);
        end
        @(posedge clk); #1 flush_i = 1'b0;
        watch_idle(40, rv, st);
        checks++; if (rv != 0 || st != 0) begin errors++; $display("FAIL flush_calc_after: valid %0d stall %0d want 0 0", rv, st); end
        // flush coincides with the last iteration
        issue(OP_DIVU, 32'd100, 32'd7, acc);
        repeat (32) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        watch_idle(10, rv, st);
        checks++; if (rv != 0 || st != 0) begin errors++; $display("FAIL flush_last_iter: valid %0d stall %0d want 0 0", rv, st); end
        // flush during DONE suppresses the pulse
        issue(OP_DIVU, 32'd5, 32'd0, acc);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL flush_done: valid %b want 0", result_valid_o); end
        @(posedge clk); #1 flush_i = 1'b0;
        // flush in IDLE blocks accept
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; md_op_i = OP_MUL; rs1_i = 32'd2; rs2_i = 32'd2;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", stall_o); end
        @(posedge clk); #1 valid_i = 1'b0; flush_i = 1'b0;
        watch_idle(40, rv, st);
        checks++; if (rv != 0 || st != 0) begin errors++; $display("FAIL flush_idle_accept: valid %0d stall %0d want 0 0", rv, st); end
    endtask

    task automatic test_reset_mid();
        logic acc; logic [31:0] res; int lat, sb;
        issue(OP_DIV, 32'd100, 32'd7, acc);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 32'h0) begin
            errors++; $display("FAIL reset_mid: stall %b valid %b result %h want 0 0 0", stall_o, result_valid_o, result_o);
        end
        @(negedge clk); rst_n = 1'b1;
        issue(OP_DIVU, 32'd9, 32'd3, acc);
        wait_result(res, lat, sb);
        checks++; if (res !== 32'd3 || lat != 33) begin errors++; $display("FAIL reset_recover: got %h lat %0d want 3 lat 33", res, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh_family();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
